uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- Receive half of the UART peripheral. Deserialises the asynchronous serial line into bytes and pushes them into the RX queue.
- Uses a 16x oversampling enable produced by the UART main clock divider.
- Frame format comes from config register B fields: data bits, parity type, stop bits.
- Reports parity, framing and overrun errors as single-cycle pulses alongside each byte.

Parameters:
- OVERSAMPLE, 16, sample_tick pulses per bit period; must be a power of two, 8 or greater.
- SYNC_STAGES, 2, number of synchroniser flops on rx.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- rx  in  1  serial line; idles high
- sample_tick  in  1  one-cycle enable at OVERSAMPLE x baud
- data_bits_count  in  2  data bits per frame = value + 5 (5..8)
- parity_type  in  2  00 none, 01 even, 10 odd, 11 none
- double_stop_bits  in  1  1 = two stop bits
- queue_full  in  1  RX queue full flag
- dout  out  8  received byte, right-aligned, unused upper bits zero
- we  out  1  one-cycle push strobe to the RX queue
- parity_err  out  1  one-cycle pulse, coincident with we
- frame_err  out  1  one-cycle pulse on a stop bit sampled low
- overrun  out  1  one-cycle pulse when a byte is dropped because the queue is full
- busy  out  1  high whenever the state is not IDLE

Behaviour:
- Reset (async, any time, including mid-frame):
  - state IDLE; shift register, tick counter and bit counter cleared.
  - Synchroniser flops set to 1.
  - dout=0; we, parity_err, frame_err, overrun, busy all 0.
- rx passes through SYNC_STAGES flops giving rx_s; rx_prev is rx_s delayed one clk.
- Tick counter: log2(OVERSAMPLE) bits, advances only on sample_tick and wraps naturally.
- States: IDLE, START, DATA, PARITY, STOP1, STOP2.
- IDLE:
  - A falling edge (rx_prev=1, rx_s=0) moves to START and clears the tick counter.
  - The frame config inputs are latched at this point; config changes mid-frame are ignored.
  - A line held low does not retrigger; a new edge is required.
- START:
  - The start bit is sampled on the tick where counter = OVERSAMPLE/2-1.
  - Sample = 1: false start, return to IDLE with no outputs.
  - Sample = 0: clear the counter, clear the bit counter, go to DATA.
- DATA:
  - Sample on the tick where counter = OVERSAMPLE-1, shifting LSB-first into the shift register.
  - After N = data_bits_count+5 samples:
    - go to PARITY if the latched parity is even or odd;
    - otherwise go to STOP1.
- PARITY:
  - Sample on the counter = OVERSAMPLE-1 tick, then go to STOP1.
  - Even: error if the XOR of the data bits and the parity bit is 1.
  - Odd: error if that XOR is 0.
- STOP1:
  - Sample on the counter = OVERSAMPLE-1 tick.
  - Go to STOP2 if the latched double_stop_bits is 1; otherwise complete the frame.
- STOP2: sample and complete the frame.
  - Framing error if either stop sample is 0.
- Completion (registered; outputs valid the clk after the final stop sample tick):
  - Go to IDLE.
  - dout is updated with the right-aligned byte.
  - queue_full=0: we=1 for one cycle; parity_err and frame_err pulse in that same cycle if set.
  - queue_full=1: we stays 0, overrun=1 for one cycle, dout is unchanged.
    - frame_err still pulses.
    - parity_err does not pulse (the byte is discarded).
- Holding values: dout holds between completions. busy drops in the same cycle that we or overrun asserts.
- sample_tick high on every clk is legal.
- Frame-to-frame: IDLE re-arms immediately, so a start edge arriving half a bit after the stop sample point is caught.

Optional Feature:
- Macro: UART_RX_MAJORITY_VOTE_EN.
- Defined: each bit value is the majority of three samples, taken at counter = S-2, S-1 and S, where S is the normal sample point. This applies to the start bit too (false-start check uses the majority).
- Undefined: single sample at S; no vote storage is synthesised.

Test Plan:
- Config 8N1, sample_tick every 4 clk, send 0xA5 -> one we pulse, dout=0xA5, parity_err=0, frame_err=0, busy low afterwards.
- Config 7-bit even parity, send 0x35 with the parity bit forced to 1 -> we pulse, dout=0x35, parity_err=1; resend with correct parity 0 -> parity_err=0.
- Config 5-bit, two stop bits, send 0x1F with the second stop bit driven low -> dout=0x1F, frame_err=1 with we; line held low afterwards -> no further frames until rx rises and falls again.
- rx low glitch of 4 ticks in IDLE -> returns to IDLE, no we, no error pulses, busy high only during the glitch window.
- Drive bytes 0x11 then 0x22 with queue_full=1 during the second -> first gives we, dout=0x11; second gives overrun=1, we=0, dout stays 0x11.
- Assert reset mid-DATA of byte 0x5A -> all outputs 0 asynchronously; next clean frame 0xC3 is received correctly.

Source files
------------

// File: rtl/uart_rx_if.sv
// RX-side bus of the UART receiver: serial line, oversampling enable, frame config,
// queue back-pressure in; received byte, push strobe and error pulses out.
// slave: used by uart_rx. master: used by whatever drives the line and consumes bytes.
interface uart_rx_if;
  logic       rx;
  logic       sample_tick;
  logic [1:0] data_bits_count;
  logic [1:0] parity_type;
  logic       double_stop_bits;
  logic       queue_full;
  logic [7:0] dout;
  logic       we;
  logic       parity_err;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  modport master (
    output rx, sample_tick, data_bits_count, parity_type, double_stop_bits, queue_full,
    input  dout, we, parity_err, frame_err, overrun, busy
  );

  modport slave (
    input  rx, sample_tick, data_bits_count, parity_type, double_stop_bits, queue_full,
    output dout, we, parity_err, frame_err, overrun, busy
  );
endinterface

// File: rtl/uart_rx.sv
// UART receiver: synchronises rx, finds the start edge, samples each bit at its centre
// using an OVERSAMPLE x baud tick, checks parity/stop bits and pushes the byte out.
// Optional feature macro: UART_RX_MAJORITY_VOTE_EN (3-sample majority per bit).
module uart_rx #(
  parameter int unsigned OVERSAMPLE  = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input logic      clk,
  input logic      reset,
  uart_rx_if.slave bus
);
  localparam int unsigned     CntW    = $clog2(OVERSAMPLE);
  localparam logic [CntW-1:0] StartPt = CntW'(OVERSAMPLE / 2 - 1);
  localparam logic [CntW-1:0] BitPt   = CntW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop1, StStop2} state_e;
  state_e state_q, state_d;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s, rx_prev_q, fall;
  logic [CntW-1:0]        cnt_q, pt;
  logic                   at_pt, bit_val;
  logic [7:0]             shift_q, dout_q;
  logic [2:0]             bit_cnt_q;
  logic [1:0]             nbits_q, par_q;
  logic                   dstop_q, par_acc_q, par_err_q, stop_bad_q;
  logic                   we_q, perr_q, ferr_q, ovr_q;
  logic                   start_frame, start_ok, shift_en, par_en, stop1_en, done, ferr_now;

  assign rx_s  = sync_q[SYNC_STAGES-1];
  assign fall  = rx_prev_q & ~rx_s;
  // Start bit is checked at its centre; every later bit one full period on.
  assign pt    = (state_q == StStart) ? StartPt : BitPt;
  assign at_pt = bus.sample_tick && (cnt_q == pt);

`ifdef UART_RX_MAJORITY_VOTE_EN
  logic [1:0] vote_q;

  // Capture the two early votes at pt-2 and pt-1; the third is the live sample at pt
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vote_q <= 2'b11;
    end else if (bus.sample_tick && (cnt_q == pt - CntW'(2))) begin
      vote_q[0] <= rx_s;
    end else if (bus.sample_tick && (cnt_q == pt - CntW'(1))) begin
      vote_q[1] <= rx_s;
    end
  end

  assign bit_val = (vote_q[0] & vote_q[1]) | (vote_q[0] & rx_s) | (vote_q[1] & rx_s);
`else
  assign bit_val = rx_s;
`endif

  // Input synchroniser and edge-detect history; idles high so reset looks like a quiet line
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q    <= '1;
      rx_prev_q <= 1'b1;
    end else begin
      sync_q    <= (sync_q << 1) | SYNC_STAGES'(bus.rx);
      rx_prev_q <= rx_s;
    end
  end

  // Next state and per-sample control strobes
  always_comb begin
    state_d     = state_q;
    start_frame = 1'b0;
    start_ok    = 1'b0;
    shift_en    = 1'b0;
    par_en      = 1'b0;
    stop1_en    = 1'b0;
    done        = 1'b0;
    ferr_now    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (fall) begin
          state_d     = StStart;
          start_frame = 1'b1;
        end
      end
      StStart: begin
        if (at_pt) begin
          if (bit_val) begin
            state_d = StIdle;
          end else begin
            state_d  = StData;
            start_ok = 1'b1;
          end
        end
      end
      StData: begin
        if (at_pt) begin
          shift_en = 1'b1;
          if (bit_cnt_q == {1'b0, nbits_q} + 3'd4) begin
            state_d = (par_q == 2'b01 || par_q == 2'b10) ? StParity : StStop1;
          end
        end
      end
      StParity: begin
        if (at_pt) begin
          par_en  = 1'b1;
          state_d = StStop1;
        end
      end
      StStop1: begin
        if (at_pt) begin
          stop1_en = 1'b1;
          if (dstop_q) begin
            state_d = StStop2;
          end else begin
            done     = 1'b1;
            ferr_now = ~bit_val;
            state_d  = StIdle;
          end
        end
      end
      StStop2: begin
        if (at_pt) begin
          done     = 1'b1;
          ferr_now = stop_bad_q | ~bit_val;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State register, frame datapath and registered completion pulses
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      nbits_q    <= '0;
      par_q      <= '0;
      dstop_q    <= 1'b0;
      par_acc_q  <= 1'b0;
      par_err_q  <= 1'b0;
      stop_bad_q <= 1'b0;
      dout_q     <= '0;
      we_q       <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
      if (start_frame || start_ok) begin
        cnt_q <= '0;
      end else if (bus.sample_tick) begin
        cnt_q <= cnt_q + 1'b1;
      end
      // Config is frozen for the whole frame from the start edge on
      if (start_frame) begin
        nbits_q    <= bus.data_bits_count;
        par_q      <= bus.parity_type;
        dstop_q    <= bus.double_stop_bits;
        par_acc_q  <= 1'b0;
        par_err_q  <= 1'b0;
        stop_bad_q <= 1'b0;
        shift_q    <= '0;
      end
      if (start_ok) begin
        bit_cnt_q <= '0;
      end
      if (shift_en) begin
        shift_q   <= {bit_val, shift_q[7:1]};
        bit_cnt_q <= bit_cnt_q + 3'd1;
        par_acc_q <= par_acc_q ^ bit_val;
      end
      if (par_en) begin
        par_err_q <= (par_q == 2'b01) ? (par_acc_q ^ bit_val) : ~(par_acc_q ^ bit_val);
      end
      if (stop1_en) begin
        stop_bad_q <= ~bit_val;
      end
      if (done) begin
        ferr_q <= ferr_now;
        if (!bus.queue_full) begin
          // LSB-first shifting leaves short words in the top bits
          dout_q <= shift_q >> (2'd3 - nbits_q);
          we_q   <= 1'b1;
          perr_q <= par_err_q;
        end else begin
          ovr_q <= 1'b1;
        end
      end
    end
  end

  assign bus.dout       = dout_q;
  assign bus.we         = we_q;
  assign bus.parity_err = perr_q;
  assign bus.frame_err  = ferr_q;
  assign bus.overrun    = ovr_q;
  assign bus.busy       = (state_q != StIdle);
endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: table of frames with expected results, plus hand sequences
// for line-held-low, start glitch, back-to-back frames and asynchronous reset mid-frame.
module tb_uart_rx;
  localparam int BitClk = 64;  // 16 ticks per bit, one tick every 4 clk

  logic clk = 1'b0;
  logic reset;
  int   tick_cnt = 0;

  uart_rx_if u_if ();

  uart_rx #(
    .OVERSAMPLE  (16),
    .SYNC_STAGES (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (u_if.slave)
  );

  always #5 clk = ~clk;

  // Tick generator: one clk-wide pulse every 4 clk
  always @(negedge clk) begin
    tick_cnt = (tick_cnt + 1) % 4;
    u_if.sample_tick = (tick_cnt == 0);
  end

  int we_tot = 0, perr_tot = 0, ferr_tot = 0, ovr_tot = 0, stray_tot = 0;

  // Pulse monitor, sampled away from the active edge
  always @(negedge clk) begin
    if (!reset) begin
      if (u_if.we) we_tot++;
      if (u_if.we && u_if.parity_err) perr_tot++;
      if (u_if.frame_err) ferr_tot++;
      if (u_if.overrun) ovr_tot++;
      if (u_if.parity_err && !u_if.we) stray_tot++;
      if (u_if.we && u_if.overrun) stray_tot++;
    end
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Drive one frame; config is scrambled after the start bit to prove it was latched
  task automatic send(input int dbc, input int ptype, input int dstop, input logic [7:0] data,
                      input bit bad_par, input bit stop1, input bit stop2);
    logic [11:0] b;
    int          n;
    logic        p;
    b = '0;
    n = 1;
    p = 1'b0;
    for (int i = 0; i < dbc + 5; i++) begin
      b[n] = data[i];
      p    = p ^ data[i];
      n++;
    end
    if (ptype == 1) begin
      b[n] = p ^ bad_par;
      n++;
    end else if (ptype == 2) begin
      b[n] = ~p ^ bad_par;
      n++;
    end
    b[n] = stop1;
    n++;
    if (dstop != 0) begin
      b[n] = stop2;
      n++;
    end
    u_if.data_bits_count  = 2'(dbc);
    u_if.parity_type      = 2'(ptype);
    u_if.double_stop_bits = (dstop != 0);
    for (int k = 0; k < n; k++) begin
      u_if.rx = b[k];
      if (k == 1) begin
        u_if.data_bits_count  = ~u_if.data_bits_count;
        u_if.parity_type      = ~u_if.parity_type;
        u_if.double_stop_bits = ~u_if.double_stop_bits;
      end
      repeat (BitClk) @(negedge clk);
    end
  endtask

  task automatic idle(input int cycles);
    u_if.rx = 1'b1;
    repeat (cycles) @(negedge clk);
  endtask

  typedef struct {
    int         dbc;
    int         ptype;
    int         dstop;
    logic [7:0] data;
    bit         bad_par;
    bit         stop1;
    bit         stop2;
    bit         qf;
    bit         hold_low;
    logic [7:0] exp_dout;
    int         exp_we;
    int         exp_perr;
    int         exp_ferr;
    int         exp_ovr;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int w0, p0, f0, o0;
    //         dbc ptyp dstp data   bad s1 s2 qf hold  dout  we pe fe ov
    vecs[0] = '{3, 0, 0, 8'hA5, 0, 1, 1, 0, 0, 8'hA5, 1, 0, 0, 0};  // 8N1
    vecs[1] = '{2, 1, 0, 8'h35, 1, 1, 1, 0, 0, 8'h35, 1, 1, 0, 0};  // 7E1, parity forced 1
    vecs[2] = '{2, 1, 0, 8'h35, 0, 1, 1, 0, 0, 8'h35, 1, 0, 0, 0};  // 7E1, correct parity 0
    vecs[3] = '{1, 2, 0, 8'h2A, 1, 1, 1, 0, 0, 8'h2A, 1, 1, 0, 0};  // 6O1, wrong parity
    vecs[4] = '{3, 3, 0, 8'hC0, 0, 1, 1, 0, 0, 8'hC0, 1, 0, 0, 0};  // type 11 means none
    vecs[5] = '{3, 0, 0, 8'h11, 0, 1, 1, 0, 0, 8'h11, 1, 0, 0, 0};
    vecs[6] = '{3, 0, 0, 8'h22, 0, 1, 1, 1, 0, 8'h11, 0, 0, 0, 1};  // queue full: dropped
    vecs[7] = '{2, 1, 0, 8'h35, 1, 0, 1, 1, 0, 8'h11, 0, 0, 1, 1};  // full + bad par + bad stop
    vecs[8] = '{3, 0, 1, 8'h96, 0, 1, 1, 0, 0, 8'h96, 1, 0, 0, 0};  // 8N2
    vecs[9] = '{0, 0, 1, 8'h1F, 0, 1, 0, 0, 1, 8'h1F, 1, 0, 1, 0};  // 5N2, stop2 low

    reset                 = 1'b1;
    u_if.rx               = 1'b1;
    u_if.sample_tick      = 1'b0;
    u_if.data_bits_count  = 2'd3;
    u_if.parity_type      = 2'd0;
    u_if.double_stop_bits = 1'b0;
    u_if.queue_full       = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_dout", int'(u_if.dout), 0);
    check("reset_pulses_busy",
          int'({u_if.we, u_if.parity_err, u_if.frame_err, u_if.overrun, u_if.busy}), 0);
    reset = 1'b0;
    idle(BitClk);

    for (int i = 0; i < 10; i++) begin
      w0 = we_tot; p0 = perr_tot; f0 = ferr_tot; o0 = ovr_tot;
      u_if.queue_full = vecs[i].qf;
      send(vecs[i].dbc, vecs[i].ptype, vecs[i].dstop, vecs[i].data,
           vecs[i].bad_par, vecs[i].stop1, vecs[i].stop2);
      u_if.rx = ~vecs[i].hold_low;
      repeat (2 * BitClk) @(negedge clk);
      u_if.queue_full = 1'b0;
      check($sformatf("v%0d_dout", i), int'(u_if.dout), int'(vecs[i].exp_dout));
      check($sformatf("v%0d_we", i), we_tot - w0, vecs[i].exp_we);
      check($sformatf("v%0d_parity_err", i), perr_tot - p0, vecs[i].exp_perr);
      check($sformatf("v%0d_frame_err", i), ferr_tot - f0, vecs[i].exp_ferr);
      check($sformatf("v%0d_overrun_busy", i), (ovr_tot - o0) * 2 + int'(u_if.busy),
            vecs[i].exp_ovr * 2);
    end

    // Line held low after the last frame must not retrigger
    w0 = we_tot;
    repeat (5 * BitClk) @(negedge clk);
    check("held_low_no_frame", we_tot - w0, 0);
    check("held_low_not_busy", int'(u_if.busy), 0);
    idle(BitClk);
    f0 = ferr_tot;
    send(0, 0, 1, 8'h0A, 0, 1, 1);
    idle(2 * BitClk);
    check("rearm_dout", int'(u_if.dout), 8'h0A);
    check("rearm_we", we_tot - w0, 1);
    check("rearm_frame_err", ferr_tot - f0, 0);

    // 4-tick low glitch in IDLE: false start
    w0 = we_tot; p0 = perr_tot; f0 = ferr_tot; o0 = ovr_tot;
    u_if.data_bits_count = 2'd3;
    u_if.parity_type     = 2'd0;
    u_if.rx = 1'b0;
    repeat (10) @(negedge clk);
    check("glitch_busy_high", int'(u_if.busy), 1);
    repeat (6) @(negedge clk);
    u_if.rx = 1'b1;
    repeat (48) @(negedge clk);
    check("glitch_busy_low", int'(u_if.busy), 0);
    idle(2 * BitClk);
    check("glitch_no_outputs", (we_tot - w0) + (perr_tot - p0) + (ferr_tot - f0) + (ovr_tot - o0),
          0);
    check("glitch_dout_held", int'(u_if.dout), 8'h0A);

    // Back-to-back frames with no idle gap
    w0 = we_tot;
    send(3, 0, 0, 8'h3C, 0, 1, 1);
    send(3, 0, 0, 8'hE7, 0, 1, 1);
    idle(2 * BitClk);
    check("b2b_we", we_tot - w0, 2);
    check("b2b_dout", int'(u_if.dout), 8'hE7);

    // Asynchronous reset in the middle of the data bits of 0x5A
    u_if.data_bits_count = 2'd3;
    u_if.rx = 1'b0;
    repeat (BitClk) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      u_if.rx = (i == 1);
      repeat (BitClk) @(negedge clk);
    end
    check("pre_reset_busy", int'(u_if.busy), 1);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("async_reset_dout", int'(u_if.dout), 0);
    check("async_reset_pulses_busy",
          int'({u_if.we, u_if.parity_err, u_if.frame_err, u_if.overrun, u_if.busy}), 0);
    u_if.rx = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    idle(BitClk);
    w0 = we_tot; f0 = ferr_tot;
    send(3, 0, 0, 8'hC3, 0, 1, 1);
    idle(2 * BitClk);
    check("post_reset_dout", int'(u_if.dout), 8'hC3);
    check("post_reset_we", we_tot - w0, 1);
    check("post_reset_frame_err", ferr_tot - f0, 0);

    check("stray_pulses", stray_tot, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
